cpu_req_master: RTL and testbench

- Synthesizable CPU-side initiator that drives the L1 cache CPU port (cpu_addr/cpu_read/cpu_write/cpu_data_in in, cpu_data_out/cpu_ready back).
- Buffers queued commands, issues each to L1, waits for completion, checks read data against an expected value, and reports data, latency and error counts.
- Sits in place of the behavioural CPU stimulus in the L1/L2/memory hierarchy, for self-checking regressions and on-chip traffic generation.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cpu_req_master_if.sv | 27 ++
 rtl/req_fifo.sv | 54 +++++
 rtl/cpu_req_master.sv | 186 ++++++++++++++++++
 tb/tb_cpu_req_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types for the CPU request master.
//   cmd_t          : one queued command (write flag, address, write data,
//                    read-check enable and expected read data)
//   master_state_t : request FSM states
//   sat_inc        : saturating increment used by the latency and event counters
package cache_pkg;

    localparam int CMD_ADDR_W = 11;
    localparam int CMD_DATA_W = 8;

    // "expect" is a reserved word, hence expect_val.
    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  check;
        logic [CMD_DATA_W-1:0] expect_val;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } master_state_t;

    // Callers truncate the result back to their own width; max_value is
    // the all-ones value of that width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cpu_req_master_if.sv
// L1 cache CPU port bundle.
//   master : drives cpu_addr, cpu_data_in, cpu_read, cpu_write;
//            receives cpu_data_out, cpu_ready
//   slave  : the L1 side, directions mirrored
// cpu_read/cpu_write are level strobes held by the master for a fixed number
// of cycles; cpu_ready is a single-cycle completion pulse from the L1.
interface cpu_req_master_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic                  cpu_ready;

    modport master (
        output cpu_addr, cpu_data_in, cpu_read, cpu_write,
        input  cpu_data_out, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
        output cpu_data_out, cpu_ready
    );
endinterface

// File: rtl/req_fifo.sv
// Synchronous command FIFO of cmd_t.
//   clk, rst    : clock, synchronous active-high reset (flushes pointers)
//   push, din   : write din when push and not full
//   pop, dout   : dout shows the head; pop advances it when not empty
//   full, empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; DEPTH must be a power of two.
module req_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/cpu_req_master.sv
// CPU-side initiator for the L1 cache port.
//   clk, rst        : clock, synchronous active-high reset
//   cmd_*           : command queue input (valid/ready)
//   cpu             : L1 CPU port (master modport)
//   rsp_*           : per-command result, rsp_valid pulses once per command,
//                     the other rsp_* hold until the next pulse
//   op_count        : completed commands, saturating
//   err_count       : mismatches plus timeouts, saturating
//   busy            : FSM active or commands queued
//   dbg_state       : current FSM state
// Handshake: a command transfers on every rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready depends only on queue occupancy, never on
// cmd_valid, and the offering side must hold its fields stable until then.
module cpu_req_master
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int DATA_WIDTH = CMD_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int REQ_HOLD   = 2,
    parameter int TIMEOUT    = 1023,
    parameter int LAT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_check,
    input  logic [DATA_WIDTH-1:0] cmd_expect,
    cpu_req_master_if.master      cpu,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [LAT_WIDTH-1:0]  rsp_latency,
    output logic                  rsp_mismatch,
    output logic                  rsp_timeout,
    output logic [LAT_WIDTH-1:0]  op_count,
    output logic [LAT_WIDTH-1:0]  err_count,
    output logic                  busy,
    output master_state_t         dbg_state
);
    localparam int HW = $clog2(REQ_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REQ_HOLD);
    // wait_cnt counts WAIT cycles already spent, so TIMEOUT-1 marks the last one.
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   CNT_MAX   = (32'd1 << LAT_WIDTH) - 32'd1;

    cmd_t                  cmd_in;
    cmd_t                  head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    master_state_t         state;
    logic [HW-1:0]         hold_cnt;
    logic [TW-1:0]         wait_cnt;
    logic [LAT_WIDTH-1:0]  lat;
    logic                  work_write;
    logic                  work_check;
    logic [DATA_WIDTH-1:0] work_expect;

    logic [LAT_WIDTH-1:0]  lat_next;
    logic [LAT_WIDTH-1:0]  op_next;
    logic [LAT_WIDTH-1:0]  err_next;
    logic                  read_mismatch;

    assign cmd_in.write      = cmd_write;
    assign cmd_in.addr       = cmd_addr;
    assign cmd_in.wdata      = cmd_wdata;
    assign cmd_in.check      = cmd_check;
    assign cmd_in.expect_val = cmd_expect;

    assign cmd_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign dbg_state = state;

    assign lat_next = LAT_WIDTH'(sat_inc(32'(lat), CNT_MAX));
    assign op_next  = LAT_WIDTH'(sat_inc(32'(op_count), CNT_MAX));
    assign err_next = LAT_WIDTH'(sat_inc(32'(err_count), CNT_MAX));

    assign read_mismatch = work_check && !work_write &&
                           (cpu.cpu_data_out != work_expect);

    req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            hold_cnt        <= '0;
            wait_cnt        <= '0;
            lat             <= '0;
            work_write      <= 1'b0;
            work_check      <= 1'b0;
            work_expect     <= '0;
            cpu.cpu_addr    <= '0;
            cpu.cpu_data_in <= '0;
            cpu.cpu_read    <= 1'b0;
            cpu.cpu_write   <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_latency     <= '0;
            rsp_mismatch    <= 1'b0;
            rsp_timeout     <= 1'b0;
            op_count        <= '0;
            err_count       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        // Pop and first ISSUE cycle share this edge.
                        work_write      <= head.write;
                        work_check      <= head.check;
                        work_expect     <= head.expect_val;
                        cpu.cpu_addr    <= head.addr;
                        cpu.cpu_data_in <= head.wdata;
                        cpu.cpu_read    <= !head.write;
                        cpu.cpu_write   <= head.write;
                        hold_cnt        <= HW'(1);
                        lat             <= LAT_WIDTH'(1);
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    // cpu_ready is deliberately ignored while strobing.
                    lat <= lat_next;
                    if (hold_cnt == HOLD_LAST) begin
                        cpu.cpu_read  <= 1'b0;
                        cpu.cpu_write <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                WAIT: begin
                    if (cpu.cpu_ready) begin
                        rsp_valid    <= 1'b1;
                        rsp_data     <= work_write ? '0 : cpu.cpu_data_out;
                        rsp_latency  <= lat;
                        rsp_mismatch <= read_mismatch;
                        rsp_timeout  <= 1'b0;
                        op_count     <= op_next;
                        if (read_mismatch) begin
                            err_count <= err_next;
                        end
                        state <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_valid    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_latency  <= lat;
                        rsp_mismatch <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        op_count     <= op_next;
                        err_count    <= err_next;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                        lat      <= lat_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_req_master.sv
// Self-checking bench for cpu_req_master.
// A behavioural L1 stub answers the CPU port: it returns its memory contents
// and raises cpu_ready for one cycle d+1 cycles after it sees the strobes
// drop (d = 1..2 for a previously touched address, 4..9 otherwise), or never
// when stub_dead is set. The reference model keeps its own memory image and
// derives each response from the command rules plus the delay the stub chose.
module tb_cpu_req_master;
    import cache_pkg::*;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int TO    = 15;
    localparam int LW    = 10;
    localparam int CMD_W = $bits(cmd_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          cmd_check = 1'b0;
    logic [DW-1:0] cmd_expect = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [LW-1:0] rsp_latency;
    logic          rsp_mismatch;
    logic          rsp_timeout;
    logic [LW-1:0] op_count;
    logic [LW-1:0] err_count;
    logic          busy;
    master_state_t dbg_state;

    cpu_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_bus ();

    cpu_req_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .REQ_HOLD   (HOLD),
        .TIMEOUT    (TO),
        .LAT_WIDTH  (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_check    (cmd_check),
        .cmd_expect   (cmd_expect),
        .cpu          (cpu_bus),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_latency  (rsp_latency),
        .rsp_mismatch (rsp_mismatch),
        .rsp_timeout  (rsp_timeout),
        .op_count     (op_count),
        .err_count    (err_count),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memories and model state ----------------
    logic [DW-1:0]    l1_mem     [2048];
    bit               l1_cached  [2048];
    logic [DW-1:0]    ref_mem    [2048];
    logic [DW-1:0]    shadow_mem [2048];
    logic [CMD_W-1:0] exp_q [$];
    int               dly_q [$];
    int               m_ops = 0;
    int               m_errs = 0;
    int               last_lat = 0;
    bit               stub_dead = 1'b0;

    // ---------------- L1 stub ----------------
    int            st_cnt;
    int            st_dly;
    bit            st_active;
    logic          st_we;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_wd;
    int            st_d;

    always @(posedge clk) begin
        if (rst) begin
            cpu_bus.cpu_ready    <= 1'b0;
            cpu_bus.cpu_data_out <= '0;
            st_cnt               <= 0;
            st_active            <= 1'b0;
        end else begin
            cpu_bus.cpu_ready <= 1'b0;
            if (cpu_bus.cpu_read || cpu_bus.cpu_write) begin
                if (st_cnt == 0) begin
                    st_addr <= cpu_bus.cpu_addr;
                    st_we   <= cpu_bus.cpu_write;
                    st_wd   <= cpu_bus.cpu_data_in;
                end else begin
                    check("strobe_addr_stable", 32'(cpu_bus.cpu_addr), 32'(st_addr));
                end
                st_cnt <= st_cnt + 1;
            end else if (st_cnt != 0) begin
                check("strobe_len", st_cnt, HOLD);
                st_cnt <= 0;
                if (stub_dead) begin
                    dly_q.push_back(-1);
                end else begin
                    st_d = l1_cached[st_addr] ? $urandom_range(1, 2) : $urandom_range(4, 9);
                    dly_q.push_back(st_d);
                    st_dly    <= st_d;
                    st_active <= 1'b1;
                end
            end
            if (st_active) begin
                if (st_dly == 1) begin
                    cpu_bus.cpu_ready    <= 1'b1;
                    cpu_bus.cpu_data_out <= st_we ? '0 : l1_mem[st_addr];
                    if (st_we) l1_mem[st_addr] = st_wd;
                    l1_cached[st_addr] = 1'b1;
                    st_active <= 1'b0;
                end else begin
                    st_dly <= st_dly - 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    cmd_t          mon_c;
    int            mon_d;
    bit            e_to;
    bit            e_mm;
    int            e_lat;
    logic [DW-1:0] e_data;

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0 || dly_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_c = exp_q.pop_front();
                mon_d = dly_q.pop_front();
                e_to  = (mon_d < 0);
                e_lat = e_to ? (HOLD + TO) : (HOLD + 2 + mon_d);
                if (e_to || mon_c.write) e_data = '0;
                else                     e_data = ref_mem[mon_c.addr];
                e_mm = !e_to && !mon_c.write && mon_c.check && (e_data != mon_c.expect_val);
                if (!e_to && mon_c.write) ref_mem[mon_c.addr] = mon_c.wdata;
                if (m_ops < 1023) m_ops++;
                if ((e_mm || e_to) && m_errs < 1023) m_errs++;
                check("rsp_data", 32'(rsp_data), 32'(e_data));
                check("rsp_mismatch", 32'(rsp_mismatch), 32'(e_mm));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
                check("rsp_latency", 32'(rsp_latency), e_lat);
                check("op_count", 32'(op_count), m_ops);
                check("err_count", 32'(err_count), m_errs);
                last_lat = int'(rsp_latency);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input bit chk, input logic [DW-1:0] ex);
        cmd_t c;
        int   t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_wdata  = wd;
        cmd_check  = chk;
        cmd_expect = ex;
        @(posedge clk);
        c.write = w; c.addr = a; c.wdata = wd; c.check = chk; c.expect_val = ex;
        exp_q.push_back(c);
        if (w) shadow_mem[a] = wd;
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    cmd_t burst_c [6];
    int   cold_lat;
    int   acc;
    int   ops_before;
    int   errs_before;
    bit   rdy;
    int   pulses;

    initial begin
        for (int i = 0; i < 2048; i++) begin
            l1_mem[i]     = 8'($urandom);
            ref_mem[i]    = l1_mem[i];
            shadow_mem[i] = l1_mem[i];
            l1_cached[i]  = 1'b0;
        end

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_read", 32'(cpu_bus.cpu_read), 32'd0);
        check("rst_cpu_write", 32'(cpu_bus.cpu_write), 32'd0);
        check("rst_cpu_addr", 32'(cpu_bus.cpu_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_rsp_latency", 32'(rsp_latency), 32'd0);
        rst = 1'b0;

        // Cold read then warm read of address 0.
        push_cmd(1'b0, 11'h000, 8'h00, 1'b1, shadow_mem[0]);
        wait_idle();
        cold_lat = last_lat;
        push_cmd(1'b0, 11'h000, 8'h00, 1'b1, shadow_mem[0]);
        wait_idle();
        check("warm_faster", 32'(last_lat < cold_lat), 32'd1);

        // Write then read back.
        push_cmd(1'b1, 11'h123, 8'hA5, 1'b0, 8'h00);
        push_cmd(1'b0, 11'h123, 8'h00, 1'b1, 8'hA5);
        wait_idle();
        check("wr_rd_data", 32'(rsp_data), 32'hA5);
        check("wr_rd_ops", 32'(op_count), 32'd4);
        check("wr_rd_errs", 32'(err_count), 32'd0);

        // Deliberate mismatch.
        push_cmd(1'b0, 11'h010, 8'h00, 1'b1, ~shadow_mem[11'h010]);
        wait_idle();
        check("mm_flag", 32'(rsp_mismatch), 32'd1);
        check("mm_errs", 32'(err_count), 32'd1);

        // Burst: one command in flight plus DEPTH queued fills the queue.
        burst_c[0] = '{write: 1'b1, addr: 11'h200, wdata: 8'h11, check: 1'b0, expect_val: 8'h00};
        burst_c[1] = '{write: 1'b0, addr: 11'h200, wdata: 8'h00, check: 1'b1, expect_val: 8'h11};
        burst_c[2] = '{write: 1'b1, addr: 11'h201, wdata: 8'h22, check: 1'b0, expect_val: 8'h00};
        burst_c[3] = '{write: 1'b0, addr: 11'h201, wdata: 8'h00, check: 1'b1, expect_val: 8'h22};
        burst_c[4] = '{write: 1'b0, addr: 11'h000, wdata: 8'h00, check: 1'b1, expect_val: shadow_mem[0]};
        burst_c[5] = '{write: 1'b0, addr: 11'h201, wdata: 8'h00, check: 1'b1, expect_val: 8'h22};
        ops_before = m_ops;
        acc = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            if (acc == 5) check("burst_full_ready", 32'(cmd_ready), 32'd0);
            cmd_valid  = 1'b1;
            cmd_write  = burst_c[acc].write;
            cmd_addr   = burst_c[acc].addr;
            cmd_wdata  = burst_c[acc].wdata;
            cmd_check  = burst_c[acc].check;
            cmd_expect = burst_c[acc].expect_val;
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back(burst_c[acc]);
                if (burst_c[acc].write) shadow_mem[burst_c[acc].addr] = burst_c[acc].wdata;
                acc++;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("burst_accepted", acc, 5);
        wait_idle();
        check("burst_ops", 32'(op_count), ops_before + 5);

        // Timeout with the L1 stub silent, then normal traffic resumes.
        errs_before = m_errs;
        stub_dead = 1'b1;
        push_cmd(1'b0, 11'h300, 8'h00, 1'b1, 8'h5A);
        wait_idle();
        stub_dead = 1'b0;
        check("to_flag", 32'(rsp_timeout), 32'd1);
        check("to_latency", 32'(rsp_latency), HOLD + TO);
        check("to_errs", 32'(err_count), errs_before + 1);
        push_cmd(1'b0, 11'h123, 8'h00, 1'b1, 8'hA5);
        wait_idle();
        check("after_to_flag", 32'(rsp_timeout), 32'd0);
        check("after_to_data", 32'(rsp_data), 32'hA5);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            bit            w;
            logic [AW-1:0] a;
            logic [DW-1:0] wd;
            logic [DW-1:0] ex;
            w  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 11'h5FF))
                                             : AW'($urandom_range(11'h040, 11'h04F));
            wd = 8'($urandom);
            ex = ($urandom_range(0, 3) == 0) ? 8'($urandom) : shadow_mem[a];
            push_cmd(w, a, wd, 1'($urandom_range(0, 1)), ex);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset while a cold read sits in WAIT.
        push_cmd(1'b0, 11'h6AB, 8'h00, 1'b1, shadow_mem[11'h6AB]);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_cpu_read", 32'(cpu_bus.cpu_read), 32'd0);
        check("mid_rst_cpu_write", 32'(cpu_bus.cpu_write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        dly_q.delete();
        m_ops  = 0;
        m_errs = 0;
        for (int i = 0; i < 2048; i++) shadow_mem[i] = ref_mem[i];
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("mid_rst_no_rsp", pulses, 0);

        push_cmd(1'b0, 11'h123, 8'h00, 1'b1, 8'hA5);
        wait_idle();
        check("post_rst_ops", 32'(op_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
